// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel gradient for raster-order 8-bit frames; emits one
// scaled (Gx, Gy) pair per pixel with the frame border forced to zero.
module sobel_gradient #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        pixel_in,
  input  logic              pixel_valid,
  output logic signed [8:0] sobel_x,
  output logic signed [8:0] sobel_y,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int DATA_W = 8;
  localparam int COL_W  = $clog2(IMG_WIDTH + 1);
  localparam int ROW_W  = $clog2(IMG_HEIGHT + 1);
  localparam int LB_W   = $clog2(IMG_WIDTH);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

  state_t state, state_nxt;

  logic [COL_W-1:0] in_col, oc_col, fl_cnt;
  logic [ROW_W-1:0] in_row, oc_row;
  logic [LB_W-1:0]  lb_ptr;

  logic accept, flush_px, emit, take, drained, border;
  logic last_in, fill_end;

  logic              shift_p0, vld_p0, border_p0;
  logic [DATA_W-1:0] pix_p0;
  logic              vld_p1, border_p1;

  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] win [3][3];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic signed [10:0] gx, gy;

  // Weighted column/row difference: (a0 + 2*a1 + a2) - (b0 + 2*b1 + b2).
  function automatic logic signed [10:0] grad(
    input logic [DATA_W-1:0] a0, input logic [DATA_W-1:0] a1, input logic [DATA_W-1:0] a2,
    input logic [DATA_W-1:0] b0, input logic [DATA_W-1:0] b1, input logic [DATA_W-1:0] b2);
    logic [10:0] pos, neg;
    pos = {3'b0, a0} + {2'b0, a1, 1'b0} + {3'b0, a2};
    neg = {3'b0, b0} + {2'b0, b1, 1'b0} + {3'b0, b2};
    return $signed(pos - neg);
  endfunction

  // Arithmetic >>> 2 (floor); |g| <= 1020 so the top bits are pure sign.
  function automatic logic signed [8:0] scale(input logic signed [10:0] g);
    return $signed(g[10:2]);
  endfunction

  assign last_in  = (in_col == COL_W'(IMG_WIDTH - 1)) && (in_row == ROW_W'(IMG_HEIGHT - 1));
  assign fill_end = (in_row == ROW_W'(1)) && (in_col == '0);
  assign drained  = !vld_p0 && !vld_p1 && out_valid;
  assign border   = (oc_row == '0) || (oc_row == ROW_W'(IMG_HEIGHT - 1)) ||
                    (oc_col == '0) || (oc_col == COL_W'(IMG_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (accept && fill_end) state_nxt = RUN;
      RUN:     if (accept && last_in) state_nxt = FLUSH;
      FLUSH:   if (fl_cnt == COL_W'(IMG_WIDTH)) state_nxt = DONE;
      DONE:    if (drained) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    accept   = pixel_valid && (state == FILL || state == RUN);
    flush_px = (state == FLUSH);
    emit     = (pixel_valid && state == RUN) || flush_px;
    take     = accept || flush_px;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_col <= '0; in_row <= '0; oc_col <= '0; oc_row <= '0;
      fl_cnt <= '0; lb_ptr <= '0;
    end else if (state == IDLE && start) begin
      in_col <= '0; in_row <= '0; oc_col <= '0; oc_row <= '0;
      fl_cnt <= '0; lb_ptr <= '0;
    end else begin
      if (accept) begin
        if (in_col == COL_W'(IMG_WIDTH - 1)) begin
          in_col <= '0;
          in_row <= in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end
      if (emit) begin
        if (oc_col == COL_W'(IMG_WIDTH - 1)) begin
          oc_col <= '0;
          oc_row <= oc_row + 1'b1;
        end else begin
          oc_col <= oc_col + 1'b1;
        end
      end
      if (flush_px) fl_cnt <= fl_cnt + 1'b1;
      if (shift_p0) lb_ptr <= (lb_ptr == LB_W'(IMG_WIDTH - 1)) ? '0 : lb_ptr + 1'b1;
    end
  end

  // Stage p0: register the accepted (or virtual flush) pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_p0 <= 1'b0;
      vld_p0   <= 1'b0;
    end else begin
      shift_p0 <= take;
      vld_p0   <= emit;
    end
  end

  always_ff @(posedge clk) begin
    pix_p0    <= flush_px ? '0 : pixel_in;
    border_p0 <= border;
  end

  // Stage p1: line buffers and 3x3 window shift
  assign lb0_rd = lb0[lb_ptr];
  assign lb1_rd = lb1[lb_ptr];

  always_ff @(posedge clk) begin
    if (shift_p0) begin
      lb1[lb_ptr] <= pix_p0;
      lb0[lb_ptr] <= lb1_rd;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb0_rd;
      win[1][2] <= lb1_rd;
      win[2][2] <= pix_p0;
    end
    border_p1 <= border_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
  end

  // Stage p2: kernel, scaling, border mask and frame completion
  assign gx = grad(win[0][2], win[1][2], win[2][2], win[0][0], win[1][0], win[2][0]);
  assign gy = grad(win[2][0], win[2][1], win[2][2], win[0][0], win[0][1], win[0][2]);

  always_ff @(posedge clk) begin
    if (reset) begin
      sobel_x    <= '0;
      sobel_y    <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= vld_p1;
      frame_done <= (state == DONE) && drained;
      if (vld_p1) begin
        sobel_x <= border_p1 ? '0 : scale(gx);
        sobel_y <= border_p1 ? '0 : scale(gy);
      end
    end
  end

endmodule

// File: tb/tb_sobel_gradient.sv
// Randomized frame-level bench for sobel_gradient against a direct
// convolution model of the image held in an array.
module tb_sobel_gradient;
  localparam int W = 8;
  localparam int H = 6;

  logic              clk = 1'b0;
  logic              reset, start, pixel_valid;
  logic [7:0]        pixel_in;
  logic signed [8:0] sobel_x, sobel_y;
  logic              out_valid, busy, frame_done;

  sobel_gradient #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .start(start), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .sobel_x(sobel_x), .sobel_y(sobel_y),
    .out_valid(out_valid), .busy(busy), .frame_done(frame_done));

  always #5 clk = ~clk;

  int img [H][W];
  int qx[$], qy[$];
  int cyc = 0, nd = 0, first_ov = -1, last_ov = -1, fd_cyc = -1, fd_busy = 0;
  int drive_cyc = -100;
  int errors = 0, checks = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (out_valid) begin
      qx.push_back(int'(sobel_x));
      qy.push_back(int'(sobel_y));
      if (first_ov < 0) first_ov = cyc;
      last_ov = cyc;
    end
    if (frame_done) begin
      nd++;
      fd_cyc  = cyc;
      fd_busy = int'(busy);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_grad(input int r, input int c, input bit ydir);
    int g;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    if (!ydir)
      g = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
        - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    else
      g = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
        - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    return g >>> 2;
  endfunction

  task automatic clear_mon();
    qx.delete(); qy.delete();
    nd = 0; first_ov = -1; last_ov = -1; fd_cyc = -1; fd_busy = 0;
  endtask

  task automatic send_frame(input int gap_pct, input bit mid_start, input int stop_at);
    int idx = 0;
    clear_mon();
    @(negedge clk); start = 1'b1; pixel_valid = 1'b0;
    @(negedge clk); start = 1'b0;
    while (idx < W*H && idx != stop_at) begin
      start = mid_start && (idx == 20);
      if (int'($urandom_range(99)) < gap_pct) begin
        pixel_valid = 1'b0;
        pixel_in    = 8'($urandom);
      end else begin
        pixel_valid = 1'b1;
        pixel_in    = 8'(img[idx / W][idx % W]);
        if (idx == W + 1) drive_cyc = cyc;
        idx++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic finish_frame(input string name, input bit timing);
    int n = 0;
    while (nd == 0 && n < 400) begin
      pixel_valid = 1'($urandom_range(1));
      pixel_in    = 8'($urandom);
      @(negedge clk);
      n++;
    end
    pixel_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk({name, "_frame_done_count"}, nd, 1);
    chk({name, "_out_count"}, qx.size(), W*H);
    for (int i = 0; i < qx.size() && i < W*H; i++) begin
      chk($sformatf("%s_x[%0d]", name, i), qx[i], ref_grad(i / W, i % W, 1'b0));
      chk($sformatf("%s_y[%0d]", name, i), qy[i], ref_grad(i / W, i % W, 1'b1));
    end
    chk({name, "_done_after_last"}, fd_cyc - last_ov, 1);
    chk({name, "_busy_at_done"}, fd_busy, 0);
    chk({name, "_busy_after"}, int'(busy), 0);
    if (timing) chk({name, "_latency"}, first_ov - drive_cyc, 3);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pixel_valid = 1'b0; pixel_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_sobel_x", int'(sobel_x), 0);
    chk("rst_sobel_y", int'(sobel_y), 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (img[r, c]) img[r][c] = 100;
    send_frame(0, 1'b0, -1);
    finish_frame("flat", 1'b1);

    foreach (img[r, c]) img[r][c] = 4 * c;
    send_frame(0, 1'b0, -1);
    finish_frame("ramp", 1'b1);
    if (qx.size() > 10) chk("ramp_x_interior", qx[10], 8);

    foreach (img[r, c]) img[r][c] = (r >= 3) ? 255 : 0;
    send_frame(0, 1'b0, -1);
    finish_frame("step", 1'b1);
    if (qy.size() > 19) chk("step_y_row2", qy[19], 255);

    foreach (img[r, c]) img[r][c] = (r >= 3) ? 0 : 255;
    send_frame(0, 1'b0, -1);
    finish_frame("invstep", 1'b1);
    if (qy.size() > 27) chk("invstep_y_row3", qy[27], -255);

    foreach (img[r, c]) img[r][c] = 0;
    img[2][3] = 1;
    send_frame(0, 1'b0, -1);
    finish_frame("impulse", 1'b1);
    if (qx.size() > 20) begin
      chk("impulse_x_c22", qx[18], 0);
      chk("impulse_x_c24", qx[20], -1);
    end

    foreach (img[r, c]) img[r][c] = int'($urandom_range(255));
    send_frame(0, 1'b0, -1);
    finish_frame("random", 1'b1);

    foreach (img[r, c]) img[r][c] = 4 * c;
    send_frame(30, 1'b1, -1);
    finish_frame("ramp_gaps", 1'b0);

    foreach (img[r, c]) img[r][c] = int'($urandom_range(255));
    send_frame(30, 1'b0, -1);
    finish_frame("random_gaps", 1'b0);

    foreach (img[r, c]) img[r][c] = 100;
    send_frame(0, 1'b0, 20);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_frame_done", int'(frame_done), 0);
    chk("midrst_sobel_x", int'(sobel_x), 0);
    chk("midrst_sobel_y", int'(sobel_y), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_frame(0, 1'b0, -1);
    finish_frame("after_rst", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sobel_gradient.md
# sobel_gradient

Streaming 3x3 Sobel gradient stage that sits directly upstream of `sobelMag`. It accepts a raster-order 8-bit greyscale frame and produces the signed horizontal and vertical gradients, `sobel_x` and `sobel_y`, pre-scaled to the 9-bit signed range that `sobelMag` consumes. It emits exactly one gradient pair per frame pixel, in raster order, with border pixels forced to zero. This keeps the downstream address counting aligned to frame positions.

## Interface
- `IMG_WIDTH`, default 512: pixels per row. Minimum 4.
- `IMG_HEIGHT`, default 512: rows per frame. Minimum 3.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high. Clock is `clk`.
- `start`  in  1  one-cycle pulse that arms the block for a new frame. Honoured only in IDLE.
- `pixel_in`  in  8  unsigned pixel value.
- `pixel_valid`  in  1  `pixel_in` is accepted on this edge. Honoured only in FILL and RUN.
- `sobel_x`  out  9  signed, scaled Gx.
- `sobel_y`  out  9  signed, scaled Gy.
- `out_valid`  out  1  `sobel_x` and `sobel_y` hold the gradient pair for the next centre pixel.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse after the last output of a frame.

## Operation
- Storage:
  - Two line buffers, each `IMG_WIDTH` x 8 bits, implemented as circular RAM or shift registers.
  - A 3x3 window register p[row][col]. p[2][2] is the newest pixel.
- Counters:
  - Input column/row counter, counting accepted pixels.
  - Output centre column/row counter.
  - Flush counter.
- State machine:
  - IDLE: outputs idle. On `start`, go to FILL and clear all counters.
  - FILL: accept the first `IMG_WIDTH`+1 pixels with no output. Then go to RUN.
  - RUN: each accepted pixel k yields the output for centre index k-(`IMG_WIDTH`+1). After pixel `IMG_WIDTH`*`IMG_HEIGHT`-1 is accepted, go to FLUSH.
  - FLUSH: inject one virtual pixel of value 0 per cycle, with valid forced high, for `IMG_WIDTH`+1 cycles. External `pixel_valid` is ignored. Then go to DONE.
  - DONE: wait until the final output has drained, assert `frame_done` for 1 cycle, return to IDLE.
- Kernel, computed in 11-bit signed arithmetic (range ±1020):
  - Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20)
  - Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02)
- Scaling: `sobel_x` = Gx >>> 2 and `sobel_y` = Gy >>> 2, arithmetic shift, rounding toward −∞. The result range is exactly −255..255, so no saturation is needed.
- Border rule: if the centre row is 0 or `IMG_HEIGHT`−1, or the centre column is 0 or `IMG_WIDTH`−1, output 0/0. Window contents that wrap across a row boundary are never used unmasked.
- Total `out_valid` pulses per frame = `IMG_WIDTH`*`IMG_HEIGHT`, exactly.
- `start` received while `busy` is high is ignored. `pixel_valid` received in IDLE, FLUSH or DONE is ignored.
- Gaps in `pixel_valid` freeze all counters and the window. No output is produced for a gap cycle.

## Timing
- Reset values:
  - `sobel_x` = 0, `sobel_y` = 0
  - `out_valid` = 0, `busy` = 0, `frame_done` = 0
  - state = IDLE, all counters = 0
- Line buffer contents are don't-care after reset.
- `busy` rises on the edge after `start` is sampled.
- Latency:
  - Pixel k, with k ≥ `IMG_WIDTH`+1, is sampled at edge E.
  - The window update completes at E+1.
  - `out_valid` and data for centre k−(`IMG_WIDTH`+1) are registered at E+2 and held for one cycle.
- Throughput: one output per clock with continuous `pixel_valid`.
- FLUSH outputs follow the same 2-cycle latency.
- `frame_done` asserts the cycle after the last `out_valid`. `busy` falls together with `frame_done`.
- A `reset` asserted mid-frame returns the block to the reset values on the next edge. A fresh `start` is then required.

## Test plan
- Flat frame (W=8, H=6, all pixels 100, continuous valid) -> 48 `out_valid` pulses, every `sobel_x`/`sobel_y` = 0, one `frame_done`, `busy` low afterwards.
- Horizontal ramp, pixel = 4·col -> interior outputs `sobel_x` = 8 and `sobel_y` = 0. Border outputs are 0/0.
- Vertical step:
  - Rows 0–2 = 0 and rows 3–5 = 255 -> interior rows 2 and 3 give `sobel_y` = 255, others 0, `sobel_x` = 0.
  - Inverted step -> `sobel_y` = −255.
- Rounding check: a single pixel of 1 at (2,3) on zero background -> centre (2,2) gives `sobel_x` = 0 and centre (2,4) gives `sobel_x` = −1.
- Random `pixel_valid` gaps (about 30 % low) on the ramp image -> an identical output sequence and count. A `start` pulsed mid-frame has no effect.
- `reset` asserted at pixel 20 -> all outputs zero on the next edge. A subsequent `start` plus a full flat frame -> 48 zero outputs and `frame_done`.
